// File: rtl/adc_fe_pkg.sv
// Shared types and helpers for the LVDS ADC front end: alignment FSM states,
// frame geometry helpers and the expected FCO frame pattern.
package adc_fe_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_e;

    localparam int MAX_BPL = 64;

    function automatic int calc_bpl(input int bits, input int lanes_per_ch);
        return bits / lanes_per_ch;
    endfunction

    function automatic int calc_frame_cycles(input int bits, input int lanes_per_ch);
        return bits / lanes_per_ch / 2;
    endfunction

    // Expected window in the low bpl bits, MSB first: bpl/2 ones then bpl/2 zeros.
    function automatic logic [MAX_BPL-1:0] fco_pattern(input int bpl);
        logic [MAX_BPL-1:0] pat;
        pat = '0;
        for (int i = 0; i < MAX_BPL; i++) begin
            if (i < bpl && i >= bpl / 2) begin
                pat[i] = 1'b1;
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/adc_lane_window.sv
// One DDR lane (or the FCO): a 2*BPL-bit shift register fed with {rise, fall}
// each cycle, and the BPL-bit frame window selected by the bitslip offset.
module adc_lane_window #(
    parameter int BPL = 8,
    localparam int OFF_W = (BPL > 1) ? $clog2(BPL) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rise,
    input  logic             fall,
    input  logic [OFF_W-1:0] offset,
    output logic [BPL-1:0]   window
);

    logic [2*BPL-1:0] shreg_q;
    logic [2*BPL-1:0] shreg_d;

    // The fall bit is later in time, so it becomes the newest bit at the LSB.
    always_comb begin
        shreg_d = {shreg_q[2*BPL-3:0], rise, fall};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign window = shreg_q[offset +: BPL];

endmodule

// File: rtl/adc_deser_align.sv
// Multi-channel LVDS ADC deserialiser: assembles BITS-wide samples per channel
// and searches the bitslip offset until the FCO window matches, then locks.
module adc_deser_align
    import adc_fe_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int LANES_PER_CH = 2,
    parameter int BITS         = 16,
    parameter int LOCK_COUNT   = 4,
    parameter int MISS_LIMIT   = 2,
    localparam int NLANES      = CHANNELS * LANES_PER_CH,
    localparam int BPL         = calc_bpl(BITS, LANES_PER_CH),
    localparam int OFF_W       = $clog2(BPL)
) (
    input  logic                       dco_clk,
    input  logic                       rst,
    input  logic [NLANES-1:0]          bit_rise,
    input  logic [NLANES-1:0]          bit_fall,
    input  logic                       fco_rise,
    input  logic                       fco_fall,
    input  logic                       auto_en,
    input  logic                       slip_req,
    output logic [CHANNELS*BITS-1:0]   word,
    output logic                       word_valid,
    output logic                       aligned,
    output logic [OFF_W-1:0]           slip_offset,
    output logic                       align_pulse,
    output logic                       align_err_pulse,
    output logic [15:0]                err_count
);

    localparam int F      = calc_frame_cycles(BITS, LANES_PER_CH);
    localparam int FC_W   = (F > 1) ? $clog2(F) : 1;
    localparam int CNT_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(MISS_LIMIT + 1);
    localparam logic [MAX_BPL-1:0] FCO_FULL = fco_pattern(BPL);
    localparam logic [BPL-1:0]     FCO_EXP  = FCO_FULL[BPL-1:0];

    if (BITS % (2 * LANES_PER_CH) != 0) begin : g_bits_check
        $error("adc_deser_align: BITS must be a multiple of 2*LANES_PER_CH");
    end

    logic [CHANNELS*BITS-1:0] frame_word;
    logic [BPL-1:0]           fco_win;

    align_state_e          state_q, state_d;
    logic [OFF_W-1:0]      offset_q, offset_d, offset_inc;
    logic [FC_W-1:0]       fc_q, fc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [MISS_W-1:0]     miss_q, miss_d, miss_inc;
    logic [15:0]           err_count_q, err_count_d;
    logic [CHANNELS*BITS-1:0] word_q, word_d;
    logic                  word_valid_q, word_valid_d;
    logic                  align_pulse_q, align_pulse_d;
    logic                  align_err_pulse_q, align_err_pulse_d;
    logic                  eval, frame_ok, manual_slip;

    // Lane 0 of each channel feeds the most significant BPL bits of its sample.
    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        adc_lane_window #(.BPL(BPL)) u_lane (
            .clk    (dco_clk),
            .rst    (rst),
            .rise   (bit_rise[i]),
            .fall   (bit_fall[i]),
            .offset (offset_q),
            .window (frame_word[(i / LANES_PER_CH) * BITS
                                + (LANES_PER_CH - 1 - (i % LANES_PER_CH)) * BPL +: BPL])
        );
    end

    adc_lane_window #(.BPL(BPL)) u_fco (
        .clk    (dco_clk),
        .rst    (rst),
        .rise   (fco_rise),
        .fall   (fco_fall),
        .offset (offset_q),
        .window (fco_win)
    );

    assign eval        = (fc_q == '0);
    assign frame_ok    = (fco_win == FCO_EXP);
    assign manual_slip = slip_req && !auto_en;
    assign offset_inc  = (offset_q == OFF_W'(BPL - 1)) ? '0 : offset_q + OFF_W'(1);
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign miss_inc    = miss_q + MISS_W'(1);

    always_comb begin
        state_d           = state_q;
        offset_d          = offset_q;
        cnt_d             = cnt_q;
        miss_d            = miss_q;
        err_count_d       = err_count_q;
        word_d            = word_q;
        word_valid_d      = 1'b0;
        align_pulse_d     = 1'b0;
        align_err_pulse_d = 1'b0;
        fc_d              = (fc_q == FC_W'(F - 1)) ? '0 : fc_q + FC_W'(1);

        // A manual slip overrides any frame result evaluated in the same cycle.
        if (manual_slip) begin
            offset_d          = offset_inc;
            state_d           = SEARCH;
            cnt_d             = '0;
            miss_d            = '0;
            align_err_pulse_d = (state_q == LOCKED);
        end else if (eval) begin
            unique case (state_q)
                SEARCH: begin
                    if (frame_ok) begin
                        if (LOCK_COUNT <= 1) begin
                            state_d       = LOCKED;
                            align_pulse_d = 1'b1;
                        end else begin
                            state_d = VERIFY;
                            cnt_d   = CNT_W'(1);
                        end
                    end else if (auto_en) begin
                        offset_d = offset_inc;
                    end
                end
                VERIFY: begin
                    if (frame_ok) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(LOCK_COUNT)) begin
                            state_d       = LOCKED;
                            align_pulse_d = 1'b1;
                            miss_d        = '0;
                        end
                    end else begin
                        state_d = SEARCH;
                        cnt_d   = '0;
                        if (auto_en) begin
                            offset_d = offset_inc;
                        end
                    end
                end
                LOCKED: begin
                    if (frame_ok) begin
                        miss_d       = '0;
                        word_valid_d = 1'b1;
                        word_d       = frame_word;
                    end else begin
                        err_count_d = (err_count_q == 16'hFFFF) ? err_count_q
                                                                : err_count_q + 16'd1;
                        if (miss_inc == MISS_W'(MISS_LIMIT)) begin
                            state_d           = SEARCH;
                            align_err_pulse_d = 1'b1;
                            miss_d            = '0;
                            cnt_d             = '0;
                            if (auto_en) begin
                                offset_d = offset_inc;
                            end
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge dco_clk) begin
        if (rst) begin
            state_q           <= SEARCH;
            offset_q          <= '0;
            fc_q              <= '0;
            cnt_q             <= '0;
            miss_q            <= '0;
            err_count_q       <= '0;
            word_q            <= '0;
            word_valid_q      <= 1'b0;
            align_pulse_q     <= 1'b0;
            align_err_pulse_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            offset_q          <= offset_d;
            fc_q              <= fc_d;
            cnt_q             <= cnt_d;
            miss_q            <= miss_d;
            err_count_q       <= err_count_d;
            word_q            <= word_d;
            word_valid_q      <= word_valid_d;
            align_pulse_q     <= align_pulse_d;
            align_err_pulse_q <= align_err_pulse_d;
        end
    end

    assign word            = word_q;
    assign word_valid      = word_valid_q;
    assign aligned         = (state_q == LOCKED);
    assign slip_offset     = offset_q;
    assign align_pulse     = align_pulse_q;
    assign align_err_pulse = align_err_pulse_q;
    assign err_count       = err_count_q;

endmodule

// File: tb/tb_adc_deser_align.sv
// Self-checking bench for adc_deser_align: table-driven alignment scenarios
// plus directed sequences for frame errors, manual slipping and mid-run reset.
module tb_adc_deser_align;

    localparam int CHANNELS     = 4;
    localparam int LANES_PER_CH = 2;
    localparam int BITS         = 16;
    localparam int NL           = CHANNELS * LANES_PER_CH;
    localparam int BPL          = BITS / LANES_PER_CH;

    typedef struct {
        int   skew;
        logic auto0;
        int   lock_cyc;
        int   exp_off;
    } align_vec_t;

    logic                     dco_clk = 1'b0;
    logic                     rst;
    logic [NL-1:0]            bit_rise;
    logic [NL-1:0]            bit_fall;
    logic                     fco_rise;
    logic                     fco_fall;
    logic                     auto_en;
    logic                     slip_req;
    logic [CHANNELS*BITS-1:0] word;
    logic                     word_valid;
    logic                     aligned;
    logic [$clog2(BPL)-1:0]   slip_offset;
    logic                     align_pulse;
    logic                     align_err_pulse;
    logic [15:0]              err_count;

    int          cyc;
    int          skew;
    int          n_checks;
    int          n_fail;
    logic [63:0] corrupt_mask;
    align_vec_t  vecs [5];

    always #5 dco_clk = ~dco_clk;

    adc_deser_align #(
        .CHANNELS     (CHANNELS),
        .LANES_PER_CH (LANES_PER_CH),
        .BITS         (BITS),
        .LOCK_COUNT   (4),
        .MISS_LIMIT   (2)
    ) dut (
        .dco_clk         (dco_clk),
        .rst             (rst),
        .bit_rise        (bit_rise),
        .bit_fall        (bit_fall),
        .fco_rise        (fco_rise),
        .fco_fall        (fco_fall),
        .auto_en         (auto_en),
        .slip_req        (slip_req),
        .word            (word),
        .word_valid      (word_valid),
        .aligned         (aligned),
        .slip_offset     (slip_offset),
        .align_pulse     (align_pulse),
        .align_err_pulse (align_err_pulse),
        .err_count       (err_count)
    );

    function automatic logic [15:0] ramp(input int c, input int f);
        return 16'(c * 'h1000 + f);
    endfunction

    function automatic logic [CHANNELS*BITS-1:0] exp_word(input int f);
        logic [CHANNELS*BITS-1:0] w;
        w = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w[c*BITS +: BITS] = ramp(c, f);
        end
        return w;
    endfunction

    // Bit b of the serial stream (rise = 2n, fall = 2n+1); skew advances the
    // stream so that the matching window sits at offset 'skew'. lane NL is FCO.
    function automatic logic stream_bit(input int lane, input int b);
        int          a;
        int          f;
        int          p;
        logic        bad;
        logic [15:0] s;
        a   = b + skew;
        f   = a / BPL;
        p   = a % BPL;
        bad = (f < 64) ? corrupt_mask[f] : 1'b0;
        if (lane == NL) begin
            return (p < BPL / 2) ^ bad;
        end
        s = ramp(lane / LANES_PER_CH, f);
        return s[BITS - 1 - (lane % LANES_PER_CH) * BPL - p];
    endfunction

    task automatic applyStimulus();
        for (int i = 0; i < NL; i++) begin
            bit_rise[i] = stream_bit(i, 2 * cyc);
            bit_fall[i] = stream_bit(i, 2 * cyc + 1);
        end
        fco_rise = stream_bit(NL, 2 * cyc);
        fco_fall = stream_bit(NL, 2 * cyc + 1);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge dco_clk);
        #1;
        cyc++;
        slip_req = 1'b0;
        applyStimulus();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) begin
            tick();
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        slip_req = 1'b0;
        @(posedge dco_clk);
        #1;
        checkOutput("rst word", word, '0);
        checkOutput("rst word_valid", word_valid, 0);
        checkOutput("rst aligned", aligned, 0);
        checkOutput("rst slip_offset", slip_offset, 0);
        checkOutput("rst align_pulse", align_pulse, 0);
        checkOutput("rst align_err_pulse", align_err_pulse, 0);
        checkOutput("rst err_count", err_count, 0);
        rst = 1'b0;
        cyc = 0;
        applyStimulus();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lk;
        rst          = 1'b1;
        bit_rise     = '0;
        bit_fall     = '0;
        fco_rise     = 1'b0;
        fco_fall     = 1'b0;
        auto_en      = 1'b0;
        slip_req     = 1'b0;
        cyc          = 0;
        skew         = 0;
        n_checks     = 0;
        n_fail       = 0;
        corrupt_mask = '0;

        // auto0 is auto_en during the first evaluation, which sees cleared shift registers.
        vecs[0] = '{skew: 0, auto0: 1'b0, lock_cyc: 17, exp_off: 0};
        vecs[1] = '{skew: 3, auto0: 1'b1, lock_cyc: 25, exp_off: 3};
        vecs[2] = '{skew: 3, auto0: 1'b0, lock_cyc: 29, exp_off: 3};
        vecs[3] = '{skew: 5, auto0: 1'b1, lock_cyc: 33, exp_off: 5};
        vecs[4] = '{skew: 7, auto0: 1'b1, lock_cyc: 41, exp_off: 7};

        for (int v = 0; v < 5; v++) begin
            skew         = vecs[v].skew;
            corrupt_mask = '0;
            auto_en      = vecs[v].auto0;
            lk           = vecs[v].lock_cyc;
            do_reset();
            tick();
            auto_en = 1'b1;
            while (cyc <= lk + 12) begin
                checkOutput($sformatf("v%0d aligned", v), aligned, (cyc >= lk));
                checkOutput($sformatf("v%0d align_pulse", v), align_pulse, (cyc == lk));
                checkOutput($sformatf("v%0d align_err_pulse", v), align_err_pulse, 0);
                checkOutput($sformatf("v%0d word_valid", v), word_valid,
                            (cyc >= lk + 4) && (cyc % 4 == 1));
                if (cyc == lk) begin
                    checkOutput($sformatf("v%0d slip_offset", v), slip_offset, vecs[v].exp_off);
                end
                if ((cyc >= lk + 4) && (cyc % 4 == 1)) begin
                    checkOutput($sformatf("v%0d word", v), word, exp_word(cyc / 4 - 1));
                end
                tick();
            end
            checkOutput($sformatf("v%0d err_count", v), err_count, 0);
        end

        $display("[TB] locked stream with corrupted FCO frames");
        skew         = 0;
        corrupt_mask = (64'd1 << 6) | (64'd1 << 9) | (64'd1 << 10);
        auto_en      = 1'b0;
        do_reset();
        tick();
        auto_en = 1'b1;
        run_to(17);
        checkOutput("c aligned", aligned, 1);
        checkOutput("c align_pulse", align_pulse, 1);
        run_to(25);
        checkOutput("c word_valid f5", word_valid, 1);
        checkOutput("c word f5", word, exp_word(5));
        run_to(29);
        checkOutput("c word_valid f6", word_valid, 0);
        checkOutput("c err_count f6", err_count, 1);
        checkOutput("c aligned f6", aligned, 1);
        checkOutput("c word hold", word, exp_word(5));
        run_to(33);
        checkOutput("c word_valid f7", word_valid, 1);
        checkOutput("c word f7", word, exp_word(7));
        checkOutput("c err_count f7", err_count, 1);
        run_to(41);
        checkOutput("c word_valid f9", word_valid, 0);
        checkOutput("c err_count f9", err_count, 2);
        checkOutput("c aligned f9", aligned, 1);
        checkOutput("c align_err_pulse f9", align_err_pulse, 0);
        run_to(45);
        checkOutput("c err_count f10", err_count, 3);
        checkOutput("c aligned f10", aligned, 0);
        checkOutput("c align_err_pulse f10", align_err_pulse, 1);
        checkOutput("c slip_offset f10", slip_offset, 1);
        run_to(46);
        checkOutput("c align_err_pulse after", align_err_pulse, 0);

        $display("[TB] manual slipping");
        skew         = 2;
        corrupt_mask = '0;
        auto_en      = 1'b0;
        do_reset();
        tick();
        slip_req = 1'b1;
        tick();
        slip_req = 1'b1;
        checkOutput("m slip_offset 1", slip_offset, 1);
        tick();
        checkOutput("m slip_offset 2", slip_offset, 2);
        run_to(20);
        checkOutput("m aligned early", aligned, 0);
        run_to(21);
        checkOutput("m aligned", aligned, 1);
        checkOutput("m align_pulse", align_pulse, 1);
        checkOutput("m slip_offset lock", slip_offset, 2);
        auto_en = 1'b1;
        run_to(22);
        slip_req = 1'b1;
        run_to(24);
        checkOutput("m ignored slip offset", slip_offset, 2);
        checkOutput("m ignored slip aligned", aligned, 1);
        run_to(25);
        checkOutput("m word_valid", word_valid, 1);
        checkOutput("m word", word, exp_word(5));
        auto_en = 1'b0;
        run_to(28);
        slip_req = 1'b1;
        run_to(29);
        checkOutput("m eval slip word_valid", word_valid, 0);
        checkOutput("m eval slip aligned", aligned, 0);
        checkOutput("m eval slip offset", slip_offset, 3);
        checkOutput("m eval slip err_count", err_count, 0);

        $display("[TB] reset while locked");
        skew         = 3;
        corrupt_mask = (64'd1 << 7);
        auto_en      = 1'b1;
        do_reset();
        run_to(33);
        checkOutput("r err_count before", err_count, 1);
        checkOutput("r aligned before", aligned, 1);
        checkOutput("r word before", word, exp_word(6));
        checkOutput("r slip_offset before", slip_offset, 3);
        corrupt_mask = '0;
        run_to(34);
        do_reset();
        run_to(24);
        checkOutput("r aligned early", aligned, 0);
        run_to(25);
        checkOutput("r relock aligned", aligned, 1);
        checkOutput("r relock offset", slip_offset, 3);
        checkOutput("r relock err_count", err_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
